// File: rtl/sd_access_arb.sv
// sd_access_arb: round-robin arbiter that shares one SD block engine between two requesters.
// Define SD_ARB_TIMEOUT_EN to compile in the RUN-state watchdog (limit TIMEOUT cycles).
module sd_access_arb #(
    parameter int unsigned ADDR_W  = 32,
    parameter logic [23:0] TIMEOUT = 24'd12_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              init_ok,
    input  logic              req0,
    input  logic              req1,
    input  logic              op0,
    input  logic              op1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              done0,
    output logic              done1,
    output logic              err0,
    output logic              err1,
    output logic              eng_start,
    output logic              eng_op,
    output logic [ADDR_W-1:0] eng_addr,
    output logic              eng_abort,
    input  logic              eng_done,
    input  logic              eng_err,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, RUN, COMPLETE} state_t;
    state_t state, state_nx;
    logic sel, last, err_q, grant, pick, tmo;
    assign grant = init_ok & (req0 | req1);
    // On a tie the port that was not served last wins
    assign pick  = (req0 & req1) ? ~last : req1;
`ifdef SD_ARB_TIMEOUT_EN
    logic [23:0] cnt;
    always_ff @(posedge clk) begin
        if (rst || state == ISSUE)
            cnt <= '0;
        else if (state == RUN && cnt != '1)
            cnt <= cnt + 24'd1;
    end
    assign tmo = (cnt == TIMEOUT - 24'd1);
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign tmo = 1'b0;
`endif
    always_comb begin
        state_nx  = state;
        eng_abort = 1'b0;
        case (state)
            IDLE:  if (grant) state_nx = ISSUE;
            ISSUE: state_nx = RUN;
            RUN: begin
                if (eng_done)
                    state_nx = COMPLETE;
                else if (!init_ok || tmo) begin
                    state_nx  = COMPLETE;
                    eng_abort = !rst;
                end
            end
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            sel      <= 1'b0;
            last     <= 1'b1;
            err_q    <= 1'b0;
            eng_op   <= 1'b0;
            eng_addr <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && grant) begin
                sel      <= pick;
                last     <= pick;
                eng_op   <= pick ? op1 : op0;
                eng_addr <= pick ? addr1 : addr0;
            end
            // Only the value written on the RUN exit cycle reaches COMPLETE
            if (state == RUN)
                err_q <= eng_done ? eng_err : 1'b1;
        end
    end
    assign busy      = (state != IDLE);
    assign eng_start = (state == ISSUE);
    assign gnt0      = busy & ~sel;
    assign gnt1      = busy & sel;
    assign done0     = (state == COMPLETE) & ~sel;
    assign done1     = (state == COMPLETE) & sel;
    assign err0      = done0 & err_q;
    assign err1      = done1 & err_q;
endmodule

// File: tb/tb_sd_access_arb.sv
// tb_sd_access_arb: self-checking bench; acts as both requesters and the SD engine.
// The model tracks the last-served port and applies the round-robin rule per transfer.
module tb_sd_access_arb;
    logic clk = 1'b0;
    logic rst, init_ok, req0, req1, op0, op1, eng_done, eng_err;
    logic [31:0] addr0, addr1, eng_addr;
    logic gnt0, gnt1, done0, done1, err0, err1, eng_start, eng_op, eng_abort, busy;
    int errors = 0;
    int checks = 0;
    bit last_m = 1'b1;

    sd_access_arb #(.ADDR_W(32), .TIMEOUT(24'd16)) dut (
        .clk(clk), .rst(rst), .init_ok(init_ok),
        .req0(req0), .req1(req1), .op0(op0), .op1(op1),
        .addr0(addr0), .addr1(addr1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .err0(err0), .err1(err1),
        .eng_start(eng_start), .eng_op(eng_op), .eng_addr(eng_addr),
        .eng_abort(eng_abort), .eng_done(eng_done), .eng_err(eng_err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One full transfer from IDLE: grant, lat RUN cycles, done, back to IDLE
    task automatic serve(input int lat, input bit e, input bit keep);
        bit w;
        logic [1:0] g;
        w = (req0 && req1) ? !last_m : req1;
        g = w ? 2'b10 : 2'b01;
        tick;
        checks++;
        if (eng_start !== 1'b1 || {gnt1, gnt0} !== g) begin
            errors++;
            $display("FAIL issue: start=%b gnt=%b expected start=1 gnt=%b", eng_start, {gnt1, gnt0}, g);
        end
        checks++;
        if (eng_op !== (w ? op1 : op0) || eng_addr !== (w ? addr1 : addr0)) begin
            errors++;
            $display("FAIL latch: op=%b addr=%h expected op=%b addr=%h", eng_op, eng_addr,
                     w ? op1 : op0, w ? addr1 : addr0);
        end
        last_m = w;
        for (int i = 1; i <= lat; i++) begin
            tick;
            if (i == lat) begin
                eng_done = 1'b1;
                eng_err  = e;
            end
            #1;
            checks++;
            if ({gnt1, gnt0} !== g || eng_start !== 1'b0 || {done1, done0} !== 2'b00 ||
                eng_abort !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL run: gnt=%b start=%b done=%b abort=%b busy=%b expected gnt=%b 0 00 0 1",
                         {gnt1, gnt0}, eng_start, {done1, done0}, eng_abort, busy, g);
            end
        end
        tick;
        eng_done = 1'b0;
        eng_err  = 1'b0;
        checks++;
        if ({done1, done0} !== g || {err1, err0} !== (e ? g : 2'b00) || {gnt1, gnt0} !== g) begin
            errors++;
            $display("FAIL done: done=%b err=%b gnt=%b expected done=%b err=%b gnt=%b",
                     {done1, done0}, {err1, err0}, {gnt1, gnt0}, g, e ? g : 2'b00, g);
        end
        if (!keep) begin
            if (w) req1 = 1'b0;
            else   req0 = 1'b0;
        end
        tick;
        checks++;
        if (busy !== 1'b0 || {gnt1, gnt0} !== 2'b00 || {done1, done0} !== 2'b00) begin
            errors++;
            $display("FAIL idle: busy=%b gnt=%b done=%b expected 0 00 00", busy, {gnt1, gnt0}, {done1, done0});
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; init_ok = 1'b0; req0 = 1'b0; req1 = 1'b0; op0 = 1'b0; op1 = 1'b0;
        addr0 = '0; addr1 = '0; eng_done = 1'b0; eng_err = 1'b0;
        repeat (3) tick;
        checks++;
        if ({gnt0, gnt1, done0, done1, err0, err1, eng_start, eng_op, eng_abort, busy} !== 10'd0 ||
            eng_addr !== 32'd0) begin
            errors++;
            $display("FAIL reset: outs=%b addr=%h expected all zero",
                     {gnt0, gnt1, done0, done1, err0, err1, eng_start, eng_op, eng_abort, busy}, eng_addr);
        end
        rst = 1'b0;
        last_m = 1'b1;
    endtask

    task automatic test_init_hold;
        req0 = 1'b1; op0 = 1'b0; addr0 = 32'h0000_1234;
        for (int i = 0; i < 50; i++) begin
            tick;
            checks++;
            if ({gnt1, gnt0} !== 2'b00 || eng_start !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL hold: cycle %0d gnt=%b start=%b busy=%b expected 00 0 0",
                         i, {gnt1, gnt0}, eng_start, busy);
            end
        end
        init_ok = 1'b1;
        serve(3, 1'b0, 1'b0);
    endtask

    task automatic test_tie;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        last_m = 1'b1;
        req0 = 1'b1; req1 = 1'b1; op0 = 1'b0; op1 = 1'b1;
        addr0 = $urandom; addr1 = $urandom;
        for (int i = 0; i < 4; i++)
            serve($urandom_range(1, 4), 1'(i), 1'b1);
        req0 = 1'b0; req1 = 1'b0;
    endtask

    task automatic test_err;
        req1 = 1'b1; op1 = 1'b1; addr1 = 32'h0000_ABCD;
        serve(4, 1'b1, 1'b0);
    endtask

    task automatic test_timeout;
        req0 = 1'b1; op0 = 1'b1; addr0 = $urandom;
        tick;
        checks++;
        if (gnt0 !== 1'b1 || eng_start !== 1'b1) begin
            errors++;
            $display("FAIL wd_issue: gnt0=%b start=%b expected 1 1", gnt0, eng_start);
        end
        last_m = 1'b0;
`ifdef SD_ARB_TIMEOUT_EN
        for (int i = 1; i <= 16; i++) begin
            tick;
            checks++;
            if (eng_abort !== (i == 16) || done0 !== 1'b0) begin
                errors++;
                $display("FAIL wd_abort: run cycle %0d abort=%b done0=%b expected %b 0", i, eng_abort, done0, i == 16);
            end
        end
        tick;
        checks++;
        if (done0 !== 1'b1 || err0 !== 1'b1 || eng_abort !== 1'b0) begin
            errors++;
            $display("FAIL wd_done: done0=%b err0=%b abort=%b expected 1 1 0", done0, err0, eng_abort);
        end
        req0 = 1'b0;
        tick;
        req0 = 1'b1; addr0 = $urandom;
        serve(16, 1'b0, 1'b0);
`else
        for (int i = 1; i <= 40; i++) begin
            tick;
            checks++;
            if (eng_abort !== 1'b0 || done0 !== 1'b0 || gnt0 !== 1'b1) begin
                errors++;
                $display("FAIL wd_none: run cycle %0d abort=%b done0=%b gnt0=%b expected 0 0 1", i, eng_abort, done0, gnt0);
            end
        end
        init_ok = 1'b0;
        #1;
        checks++;
        if (eng_abort !== 1'b1) begin
            errors++;
            $display("FAIL wd_loss_abort: abort=%b expected 1", eng_abort);
        end
        tick;
        checks++;
        if (done0 !== 1'b1 || err0 !== 1'b1) begin
            errors++;
            $display("FAIL wd_loss_done: done0=%b err0=%b expected 1 1", done0, err0);
        end
        init_ok = 1'b1;
        req0 = 1'b0;
        tick;
`endif
    endtask

    task automatic test_init_loss;
        req1 = 1'b1; op1 = 1'b0; addr1 = $urandom;
        repeat (3) tick;
        last_m = 1'b1;
        init_ok = 1'b0;
        #1;
        checks++;
        if (eng_abort !== 1'b1 || gnt1 !== 1'b1) begin
            errors++;
            $display("FAIL loss_abort: abort=%b gnt1=%b expected 1 1", eng_abort, gnt1);
        end
        tick;
        checks++;
        if (done1 !== 1'b1 || err1 !== 1'b1 || eng_abort !== 1'b0) begin
            errors++;
            $display("FAIL loss_done: done1=%b err1=%b abort=%b expected 1 1 0", done1, err1, eng_abort);
        end
        req1 = 1'b0; req0 = 1'b1; addr0 = $urandom;
        for (int i = 0; i < 10; i++) begin
            tick;
            checks++;
            if ({gnt1, gnt0} !== 2'b00 || busy !== 1'b0) begin
                errors++;
                $display("FAIL loss_hold: gnt=%b busy=%b expected 00 0", {gnt1, gnt0}, busy);
            end
        end
        init_ok = 1'b1;
        serve(2, 1'b0, 1'b0);
        // engine completion and init loss in the same cycle: completion wins
        req1 = 1'b1; addr1 = $urandom;
        tick;
        tick;
        last_m = 1'b1;
        init_ok = 1'b0; eng_done = 1'b1; eng_err = 1'b0;
        #1;
        checks++;
        if (eng_abort !== 1'b0) begin
            errors++;
            $display("FAIL race_abort: abort=%b expected 0", eng_abort);
        end
        tick;
        eng_done = 1'b0;
        checks++;
        if (done1 !== 1'b1 || err1 !== 1'b0) begin
            errors++;
            $display("FAIL race_done: done1=%b err1=%b expected 1 0", done1, err1);
        end
        req1 = 1'b0;
        tick;
        init_ok = 1'b1;
    endtask

    task automatic test_rst_mid;
        req0 = 1'b1; req1 = 1'b0; addr0 = $urandom | 32'h1;
        repeat (3) tick;
        rst = 1'b1; init_ok = 1'b0;
        #1;
        checks++;
        if (eng_abort !== 1'b0) begin
            errors++;
            $display("FAIL rst_abort: abort=%b expected 0", eng_abort);
        end
        tick;
        checks++;
        if ({gnt0, gnt1, done0, done1, err0, err1, eng_start, eng_op, eng_abort, busy} !== 10'd0 ||
            eng_addr !== 32'd0) begin
            errors++;
            $display("FAIL rst_out: outs=%b addr=%h expected all zero",
                     {gnt0, gnt1, done0, done1, err0, err1, eng_start, eng_op, eng_abort, busy}, eng_addr);
        end
        rst = 1'b0; init_ok = 1'b1; last_m = 1'b1;
        req1 = 1'b1; addr1 = $urandom;
        serve(3, 1'b1, 1'b0);
        serve(2, 1'b0, 1'b0);
    endtask

    task automatic test_random;
        for (int t = 0; t < 60; t++) begin
            if (!req0 && $urandom_range(0, 1)) begin
                req0 = 1'b1; op0 = 1'($urandom_range(0, 1)); addr0 = $urandom;
            end
            if (!req1 && $urandom_range(0, 1)) begin
                req1 = 1'b1; op1 = 1'($urandom_range(0, 1)); addr1 = $urandom;
            end
            if (!req0 && !req1) begin
                req0 = 1'b1; op0 = 1'($urandom_range(0, 1)); addr0 = $urandom;
            end
            serve($urandom_range(1, 6), 1'($urandom_range(0, 1)), 1'b0);
        end
        req0 = 1'b0; req1 = 1'b0;
        tick;
    endtask

    initial begin
        test_reset;
        test_init_hold;
        test_tie;
        test_err;
        test_timeout;
        test_init_loss;
        test_rst_mid;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
